// File: rtl/mips8_pkg.sv
// Shared definitions for the 8-bit pipelined core: bus widths, opcodes and the
// fetch-queue entry layout.
package mips8_pkg;

  localparam int AW = 8;
  localparam int DW = 32;

  localparam logic [DW-1:0] NOP_WORD = '0;

  localparam logic [7:0] CMD_ADD   = 8'h01;
  localparam logic [7:0] CMD_LOAD  = 8'h02;
  localparam logic [7:0] CMD_STORE = 8'h03;
  localparam logic [7:0] CMD_BEQ   = 8'h08;

  typedef struct packed {
    logic [DW-1:0] word;
    logic [AW-1:0] pc;
  } fetch_entry_t;

  // Opcode lives in the top byte of an instruction word.
  function automatic logic [7:0] opcode_of(input logic [DW-1:0] w);
    return w[DW-1 -: 8];
  endfunction

endpackage

// File: rtl/instr_fetch_queue_if.sv
// Fetch-stage bus: program RAM read port, branch redirect, and the
// valid/ready command channel into the core's decode register.
interface instr_fetch_queue_if #(
  parameter int DEPTH = 4
) ();
  import mips8_pkg::*;

  localparam int LW = $clog2(DEPTH) + 1;

  logic          imem_rden;
  logic [AW-1:0] imem_addr;
  logic [DW-1:0] imem_q;
  logic          redirect;
  logic [AW-1:0] redirect_addr;
  logic          halt;
  logic          cmd_ready;
  logic          cmd_valid;
  logic [DW-1:0] cmd_word;
  logic [AW-1:0] cmd_pc;
  logic [LW-1:0] level;

  modport master (
    output imem_rden, imem_addr, cmd_valid, cmd_word, cmd_pc, level,
    input  imem_q, redirect, redirect_addr, halt, cmd_ready
  );

  modport slave (
    input  imem_rden, imem_addr, cmd_valid, cmd_word, cmd_pc, level,
    output imem_q, redirect, redirect_addr, halt, cmd_ready
  );

endinterface

// File: rtl/instr_fetch_queue_fifo.sv
// Small synchronous FIFO of fetch entries with a flush input and an occupancy
// count; the head is read straight from the array so a push is visible next cycle.
module sync_fifo
  import mips8_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  fetch_entry_t           i_push_data,
  input  logic                   i_pop,
  output fetch_entry_t           o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  fetch_entry_t  r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // The fetch credit rule must make these unreachable.
      assert (!(i_push && !i_pop && r_count == FULL));
      assert (!(i_pop && r_count == '0));
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (i_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: streams program RAM words into a small queue for the decode
// register, flushing and refetching on taken branches.
module instr_fetch_queue
  import mips8_pkg::*;
#(
  parameter int            DEPTH = 4,
  parameter logic [DW-1:0] NOP   = NOP_WORD
) (
  input  logic                clk,
  input  logic                reset,
  instr_fetch_queue_if.master bus
);

  localparam int          LW      = $clog2(DEPTH) + 1;
  localparam logic [LW:0] DEPTH_W = (LW+1)'(DEPTH);

  logic [AW-1:0] r_fetch_pc;
  logic [AW-1:0] r_ret_pc;
  logic          r_inflight;
  logic          r_epoch;
  logic          r_tag;

  logic [LW-1:0] w_count;
  logic [LW:0]   w_occ;
  logic          w_issue;
  logic          w_push;
  logic          w_pop;
  logic          w_valid;
  fetch_entry_t  w_head;
  fetch_entry_t  w_push_entry;

  // Credit counts the outstanding read but not a same-cycle pop.
  assign w_occ   = {1'b0, w_count} + {{LW{1'b0}}, r_inflight};
  assign w_issue = !reset && (bus.redirect || (!bus.halt && w_occ < DEPTH_W));

  assign bus.imem_rden = w_issue;
  assign bus.imem_addr = bus.redirect ? bus.redirect_addr : r_fetch_pc;

  assign w_push       = r_inflight && (r_tag == r_epoch) && !bus.redirect;
  assign w_push_entry = '{word: bus.imem_q, pc: r_ret_pc};
  assign w_valid      = !reset && (w_count != '0);
  assign w_pop        = w_valid && bus.cmd_ready && !bus.redirect;

  assign bus.cmd_valid = w_valid;
  assign bus.cmd_word  = w_valid ? w_head.word : NOP;
  assign bus.cmd_pc    = w_valid ? w_head.pc : '0;
  assign bus.level     = reset ? '0 : w_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc <= '0;
      r_ret_pc   <= '0;
      r_inflight <= 1'b0;
      r_epoch    <= 1'b0;
      r_tag      <= 1'b0;
    end else begin
      r_inflight <= w_issue;
      if (w_issue) begin
        r_ret_pc   <= bus.imem_addr;
        r_fetch_pc <= bus.imem_addr + AW'(1);
        // A redirect read belongs to the epoch that starts at this edge.
        r_tag      <= r_epoch ^ bus.redirect;
      end
      if (bus.redirect) begin
        r_epoch <= ~r_epoch;
      end
    end
  end

  sync_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .i_flush    (bus.redirect),
    .i_push     (w_push),
    .i_push_data(w_push_entry),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_count    (w_count)
  );

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: a scoreboard of expected (pc, word)
// pairs is filled by the stimulus and drained by a monitor on each accepted command.
module tb_instr_fetch_queue;
  import mips8_pkg::*;

  logic clk = 1'b0;
  logic reset;

  int checks = 0;
  int errors = 0;

  logic [7:0]  exp_pc_q[$];
  logic [31:0] exp_word_q[$];

  instr_fetch_queue_if #(.DEPTH(4)) bus ();

  instr_fetch_queue #(.DEPTH(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Program RAM model: RAM[i] = 32'h0100_0000 + i, one-cycle read latency.
  always @(posedge clk) begin
    if (bus.imem_rden) begin
      bus.imem_q <= {24'h010000, bus.imem_addr};
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic expect_pc(input logic [7:0] p);
    exp_pc_q.push_back(p);
    exp_word_q.push_back({24'h010000, p});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  // Monitor: every accepted command must match the scoreboard head; idle cycles show NOP.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.cmd_valid) begin
        if (bus.cmd_ready && !bus.redirect) begin
          if (exp_pc_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected: got pc %h word %h expected no command", bus.cmd_pc, bus.cmd_word);
          end else begin
            logic [7:0]  epc;
            logic [31:0] ew;
            epc = exp_pc_q.pop_front();
            ew  = exp_word_q.pop_front();
            chk("pop_pc", 32'(bus.cmd_pc), 32'(epc));
            chk("pop_word", bus.cmd_word, ew);
          end
        end
      end else begin
        chk("idle_word_nop", bus.cmd_word, NOP_WORD);
        chk("idle_pc_zero", 32'(bus.cmd_pc), 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] t2_rden  [5];
    logic [31:0] t2_addr  [5];
    logic [31:0] t2_level [5];
    t2_rden  = '{1, 1, 1, 0, 0};
    t2_addr  = '{1, 2, 3, 0, 0};
    t2_level = '{0, 1, 2, 3, 4};

    reset             = 1'b1;
    bus.redirect      = 1'b0;
    bus.redirect_addr = 8'h00;
    bus.halt          = 1'b0;
    bus.cmd_ready     = 1'b1;
    repeat (3) step();
    neg();
    chk("rst_valid", 32'(bus.cmd_valid), 0);
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_rden", 32'(bus.imem_rden), 0);
    chk("rst_word", bus.cmd_word, NOP_WORD);
    chk("rst_pc", 32'(bus.cmd_pc), 0);

    // Test 1: streaming from reset release
    step();
    reset = 1'b0;
    for (int p = 0; p < 6; p++) expect_pc(8'(p));
    neg();
    chk("t1_c0_rden", 32'(bus.imem_rden), 1);
    chk("t1_c0_addr", 32'(bus.imem_addr), 0);
    chk("t1_c0_valid", 32'(bus.cmd_valid), 0);
    step(); neg();
    chk("t1_c1_addr", 32'(bus.imem_addr), 1);
    chk("t1_c1_valid", 32'(bus.cmd_valid), 0);
    step(); neg();
    chk("t1_c2_valid", 32'(bus.cmd_valid), 1);
    chk("t1_c2_pc", 32'(bus.cmd_pc), 0);
    repeat (6) step();

    // Reset mid-stream
    reset = 1'b1;
    bus.cmd_ready = 1'b0;
    neg();
    chk("mrst_valid", 32'(bus.cmd_valid), 0);
    chk("mrst_rden", 32'(bus.imem_rden), 0);
    chk("t1_sb_drained", 32'(exp_pc_q.size()), 0);
    step();
    reset = 1'b0;
    neg();
    chk("mrst_next_valid", 32'(bus.cmd_valid), 0);
    chk("mrst_next_level", 32'(bus.level), 0);
    chk("mrst_first_addr", 32'(bus.imem_addr), 0);
    chk("mrst_first_rden", 32'(bus.imem_rden), 1);

    // Test 2: cmd_ready held low fills the queue
    for (int k = 0; k < 5; k++) begin
      step(); neg();
      chk("t2_rden", 32'(bus.imem_rden), t2_rden[k]);
      if (t2_rden[k] == 1) chk("t2_addr", 32'(bus.imem_addr), t2_addr[k]);
      chk("t2_level", 32'(bus.level), t2_level[k]);
    end
    step();
    bus.cmd_ready = 1'b1;
    expect_pc(8'h00);
    neg();
    chk("t2_full_level", 32'(bus.level), 4);
    chk("t2_full_rden", 32'(bus.imem_rden), 0);
    step();
    bus.cmd_ready = 1'b0;
    neg();
    chk("t2_refill_addr", 32'(bus.imem_addr), 4);
    chk("t2_level3", 32'(bus.level), 3);

    // Test 3: redirect with level=3 and a read in flight
    step();
    bus.redirect      = 1'b1;
    bus.redirect_addr = 8'h20;
    bus.cmd_ready     = 1'b1;
    expect_pc(8'h20);
    expect_pc(8'h21);
    neg();
    chk("t3_rden", 32'(bus.imem_rden), 1);
    chk("t3_addr", 32'(bus.imem_addr), 32'h20);
    step();
    bus.redirect = 1'b0;
    neg();
    chk("t3_bubble", 32'(bus.cmd_valid), 0);
    chk("t3_next_addr", 32'(bus.imem_addr), 32'h21);
    step(); step();

    // Test 4: back-to-back redirects
    step();
    bus.redirect      = 1'b1;
    bus.redirect_addr = 8'h10;
    neg();
    chk("t4_addr10", 32'(bus.imem_addr), 32'h10);
    step();
    bus.redirect_addr = 8'h30;
    expect_pc(8'h30);
    expect_pc(8'h31);
    neg();
    chk("t4_addr30", 32'(bus.imem_addr), 32'h30);
    step();
    bus.redirect = 1'b0;
    neg();
    chk("t4_bubble", 32'(bus.cmd_valid), 0);
    step(); step();

    // Test 5: wrap-around from 8'hFE
    step();
    bus.redirect      = 1'b1;
    bus.redirect_addr = 8'hFE;
    expect_pc(8'hFE);
    expect_pc(8'hFF);
    expect_pc(8'h00);
    expect_pc(8'h01);
    neg();
    chk("t5_addr", 32'(bus.imem_addr), 32'hFE);
    step();
    bus.redirect = 1'b0;
    neg();
    chk("t5_bubble", 32'(bus.cmd_valid), 0);
    step(); neg();
    chk("t5_first_pc", 32'(bus.cmd_pc), 32'hFE);
    step(); step(); step();

    // Test 6: halt drains the queue
    step();
    bus.cmd_ready = 1'b0;
    bus.halt      = 1'b1;
    expect_pc(8'h02);
    expect_pc(8'h03);
    neg();
    chk("t6_rden_c0", 32'(bus.imem_rden), 0);
    chk("t6_level_c0", 32'(bus.level), 1);
    step();
    bus.cmd_ready = 1'b1;
    neg();
    chk("t6_level2", 32'(bus.level), 2);
    chk("t6_rden_c1", 32'(bus.imem_rden), 0);
    step(); neg();
    chk("t6_rden_c2", 32'(bus.imem_rden), 0);
    step(); neg();
    chk("t6_empty_valid", 32'(bus.cmd_valid), 0);
    chk("t6_empty_word", bus.cmd_word, NOP_WORD);
    chk("t6_empty_level", 32'(bus.level), 0);
    chk("t6_empty_rden", 32'(bus.imem_rden), 0);
    step(); neg();
    chk("t6_still_empty", 32'(bus.cmd_valid), 0);
    chk("sb_drained", 32'(exp_pc_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
